// File: rtl/int_to_fp_pipe.sv
// Three-stage pipelined integer to floating-point converter with valid/ready handshake.
// Optional feature macro: INT_TO_FP_RND_MODES_EN (all four rounding modes; otherwise RNE only).
module int_to_fp_pipe #(
  parameter int INTn = 32,
  parameter int NEXP = 8,
  parameter int NSIG = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INTn-1:0]      in_data,
  input  logic                 in_signed,
  input  logic [1:0]           rnd_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NEXP+NSIG:0]   out_data,
  output logic [4:0]           out_flags
);

  localparam int LZW = $clog2(INTn);
  localparam int EW  = NEXP + LZW + 2;
  localparam int W   = NEXP + NSIG + 1;
  localparam logic [EW-1:0] BIAS_C    = EW'((1 << (NEXP - 1)) - 1);
  localparam logic [EW-1:0] EXP_INF_C = EW'((1 << NEXP) - 1);

  logic            r_v1, r_v2, r_v3;
  logic            r_sign1, r_sign2;
  logic [INTn-1:0] r_mag1;
  logic [INTn-2:0] r_frac2;
  logic [EW-1:0]   r_exp2;
  logic            r_zero2;
  logic [W-1:0]    r_data3;
  logic [4:0]      r_flags3;

  logic w_adv1, w_adv2, w_adv3, w_in_ready, w_acc;
  logic w_neg;
  logic [INTn-1:0] w_mag;
  logic [1:0] w_mode;

  // Handshake chain: a stage moves when its successor is empty or moving too.
  assign w_adv3     = r_v3 & out_ready;
  assign w_adv2     = r_v2 & (~r_v3 | w_adv3);
  assign w_adv1     = r_v1 & (~r_v2 | w_adv2);
  assign w_in_ready = ~r_v1 | w_adv1;
  assign w_acc      = in_valid & w_in_ready;

  assign w_neg = in_signed & in_data[INTn-1];
  assign w_mag = w_neg ? (-in_data) : in_data;

`ifdef INT_TO_FP_RND_MODES_EN
  logic [1:0] r_mode1, r_mode2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode1 <= 2'd0;
      r_mode2 <= 2'd0;
    end else begin
      if (w_acc) r_mode1 <= rnd_mode;
      if (r_v1 && (!r_v2 || w_adv2)) r_mode2 <= r_mode1;
    end
  end

  assign w_mode = r_mode2;
`else
  logic w_unused_mode;
  assign w_unused_mode = |rnd_mode;
  assign w_mode = 2'd0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_sign1 <= 1'b0;
      r_mag1  <= '0;
    end else if (w_in_ready) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_sign1 <= w_neg;
        r_mag1  <= w_mag;
      end
    end
  end

  // Log2 shift tree: each level tests the top 2^g bits and shifts them out when clear.
  logic [INTn-1:0] w_sh [0:LZW];
  logic [LZW-1:0]  w_lzc;
  assign w_sh[LZW] = r_mag1;

  for (genvar g = 0; g < LZW; g++) begin : gen_lzc
    localparam int SH = 1 << g;
    assign w_lzc[g] = (w_sh[g+1][INTn-1 -: SH] == '0);
    assign w_sh[g]  = w_lzc[g] ? (w_sh[g+1] << SH) : w_sh[g+1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2    <= 1'b0;
      r_sign2 <= 1'b0;
      r_frac2 <= '0;
      r_exp2  <= '0;
      r_zero2 <= 1'b1;
    end else if (!r_v2 || w_adv2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_sign2 <= r_sign1;
        r_frac2 <= w_sh[0][INTn-2:0];
        r_exp2  <= EW'(INTn - 1) - EW'(w_lzc);
        r_zero2 <= (r_mag1 == '0);
      end
    end
  end

  logic [NSIG-1:0] w_frac;
  logic            w_guard, w_sticky, w_inexact, w_rup, w_ovf, w_to_inf;
  logic [NSIG:0]   w_frac_rnd;
  logic [EW-1:0]   w_exp_b;
  logic [W-1:0]    w_data;
  logic [4:0]      w_flags;

  assign w_frac     = r_frac2[INTn-2 -: NSIG];
  assign w_guard    = r_frac2[INTn-2-NSIG];
  assign w_sticky   = |r_frac2[INTn-3-NSIG:0];
  assign w_inexact  = w_guard | w_sticky;
  assign w_frac_rnd = {1'b0, w_frac} + {{NSIG{1'b0}}, w_rup};
  assign w_exp_b    = r_exp2 + BIAS_C + {{(EW-1){1'b0}}, w_frac_rnd[NSIG]};
  assign w_ovf      = (w_exp_b >= EXP_INF_C);

  // Round-up decision and overflow saturation direction for the selected mode.
  always_comb begin
    w_rup    = 1'b0;
    w_to_inf = 1'b1;
    case (w_mode)
      2'd0: begin
        w_rup    = w_guard & (w_sticky | w_frac[0]);
        w_to_inf = 1'b1;
      end
      2'd1: begin
        w_rup    = 1'b0;
        w_to_inf = 1'b0;
      end
      2'd2: begin
        w_rup    = r_sign2 & w_inexact;
        w_to_inf = r_sign2;
      end
      2'd3: begin
        w_rup    = ~r_sign2 & w_inexact;
        w_to_inf = ~r_sign2;
      end
      default: begin
        w_rup    = 1'b0;
        w_to_inf = 1'b1;
      end
    endcase
  end

  // Pack: zero bypass, overflow saturation, or normal result.
  always_comb begin
    w_data  = '0;
    w_flags = 5'd0;
    if (r_zero2) begin
      w_data  = '0;
      w_flags = 5'd0;
    end else if (w_ovf) begin
      w_flags = 5'b10100;
      if (w_to_inf) begin
        w_data = {r_sign2, {NEXP{1'b1}}, {NSIG{1'b0}}};
      end else begin
        w_data = {r_sign2, {(NEXP-1){1'b1}}, 1'b0, {NSIG{1'b1}}};
      end
    end else begin
      w_data  = {r_sign2, w_exp_b[NEXP-1:0], w_frac_rnd[NSIG-1:0]};
      w_flags = {w_inexact, 4'b0000};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v3     <= 1'b0;
      r_data3  <= '0;
      r_flags3 <= 5'd0;
    end else if (!r_v3 || w_adv3) begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_data3  <= w_data;
        r_flags3 <= w_flags;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_v3;
  assign out_data  = r_data3;
  assign out_flags = r_flags3;

endmodule

// File: tb/tb_int_to_fp_pipe.sv
// Self-checking bench for int_to_fp_pipe: directed cases, random streams with
// back-pressure, and reset flush, against an arithmetic reference model.
module tb_int_to_fp_pipe;

`ifdef INT_TO_FP_RND_MODES_EN
  localparam bit MODES_EN = 1'b1;
`else
  localparam bit MODES_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_signed, out_valid, out_ready;
  logic [31:0] in_data;
  logic [1:0]  rnd_mode;
  logic [15:0] out_data;
  logic [4:0]  out_flags;

  logic        in_valid_h, in_ready_h, in_signed_h, out_valid_h, out_ready_h;
  logic [31:0] in_data_h;
  logic [1:0]  rnd_mode_h;
  logic [15:0] out_data_h;
  logic [4:0]  out_flags_h;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  int_to_fp_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_signed(in_signed), .rnd_mode(rnd_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_flags(out_flags)
  );

  int_to_fp_pipe #(.INTn(32), .NEXP(5), .NSIG(10)) dut_h (
    .clk(clk), .rst(rst), .in_valid(in_valid_h), .in_ready(in_ready_h),
    .in_data(in_data_h), .in_signed(in_signed_h), .rnd_mode(rnd_mode_h),
    .out_valid(out_valid_h), .out_ready(out_ready_h), .out_data(out_data_h),
    .out_flags(out_flags_h)
  );

  // Reference: exact integer quotient/remainder rounding, then range check.
  function automatic void ref_conv(input logic [31:0] d, input bit s, input logic [1:0] m,
                                   input int nexp, input int nsig,
                                   output logic [15:0] od, output logic [4:0] of);
    longint unsigned mag, q, rem, half, res;
    int e, sh, bias, be;
    bit neg, up, to_inf;
    logic [1:0] mm;
    mm  = MODES_EN ? m : 2'd0;
    neg = s && d[31];
    mag = neg ? (64'd4294967296 - {32'd0, d}) : {32'd0, d};
    od  = 16'd0;
    of  = 5'd0;
    if (mag == 64'd0) return;
    e = 63;
    while (((mag >> e) & 64'd1) == 64'd0) e--;
    if (e > nsig) begin
      sh   = e - nsig;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = 64'd1 << (sh - 1);
    end else begin
      q    = mag << (nsig - e);
      rem  = 64'd0;
      half = 64'd1;
    end
    case (mm)
      2'd0:    up = (rem > half) || (rem == half && q[0]);
      2'd1:    up = 1'b0;
      2'd2:    up = neg && (rem != 64'd0);
      default: up = !neg && (rem != 64'd0);
    endcase
    if (up) q = q + 64'd1;
    if (q == (64'd1 << (nsig + 1))) begin
      q = q >> 1;
      e = e + 1;
    end
    bias = (1 << (nexp - 1)) - 1;
    be   = e + bias;
    if (be >= (1 << nexp) - 1) begin
      to_inf = (mm == 2'd0) || (mm == 2'd3 && !neg) || (mm == 2'd2 && neg);
      res = to_inf ? (((64'd1 << nexp) - 64'd1) << nsig)
                   : ((((64'd1 << nexp) - 64'd2) << nsig) | ((64'd1 << nsig) - 64'd1));
      of  = 5'h14;
    end else begin
      res = (longint'(be) << nsig) | (q - (64'd1 << nsig));
      of  = (rem != 64'd0) ? 5'h10 : 5'h00;
    end
    if (neg) res = res | (64'd1 << (nexp + nsig));
    od = res[15:0];
  endfunction

  task automatic run_beat(input logic [31:0] d, input bit s, input logic [1:0] m,
                          output logic [15:0] od, output logic [4:0] of, output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_signed = s; rnd_mode = m; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1; od = 16'hxxxx; of = 5'bxxxxx;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i; od = out_data; of = out_flags;
        break;
      end
    end
  endtask

  task automatic run_beat_h(input logic [31:0] d, input bit s, input logic [1:0] m,
                            output logic [15:0] od, output logic [4:0] of);
    @(negedge clk);
    in_valid_h = 1'b1; in_data_h = d; in_signed_h = s; rnd_mode_h = m; out_ready_h = 1'b1;
    @(posedge clk);
    #1 in_valid_h = 1'b0;
    od = 16'hxxxx; of = 5'bxxxxx;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (out_valid_h) begin
        od = out_data_h; of = out_flags_h;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_cnt++;
    if (out_valid !== 1'b0 || out_valid_h !== 1'b0) $display("FAIL reset_valid got %b/%b want 0", out_valid, out_valid_h);
    else pass_cnt++;
    chk_cnt++;
    if (out_data !== 16'h0000 || out_flags !== 5'h00) $display("FAIL reset_data got %h/%h want 0000/00", out_data, out_flags);
    else pass_cnt++;
    chk_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
    else pass_cnt++;
  endtask

  typedef struct { logic [31:0] d; bit s; logic [1:0] m; logic [15:0] ed; logic [4:0] ef; } vec_t;

  task automatic test_directed();
    vec_t tbl[$];
    logic [15:0] od; logic [4:0] of; int lat;
    tbl.push_back('{32'd1,        1'b1, 2'd0, 16'h3F80, 5'h00});
    tbl.push_back('{32'hFFFFFFFF, 1'b1, 2'd0, 16'hBF80, 5'h00});
    tbl.push_back('{32'd0,        1'b1, 2'd0, 16'h0000, 5'h00});
    tbl.push_back('{32'd0,        1'b0, 2'd3, 16'h0000, 5'h00});
    tbl.push_back('{32'd257,      1'b1, 2'd0, 16'h4380, 5'h10});
    tbl.push_back('{32'd257,      1'b1, 2'd3, MODES_EN ? 16'h4381 : 16'h4380, 5'h10});
    tbl.push_back('{32'd257,      1'b1, 2'd1, 16'h4380, 5'h10});
    tbl.push_back('{-32'sd257,    1'b1, 2'd2, MODES_EN ? 16'hC381 : 16'hC380, 5'h10});
    tbl.push_back('{32'h80000000, 1'b1, 2'd0, 16'hCF00, 5'h00});
    tbl.push_back('{32'h80000000, 1'b0, 2'd0, 16'h4F00, 5'h00});
    tbl.push_back('{32'h7FFFFFFF, 1'b1, 2'd0, 16'h4F00, 5'h10});
    tbl.push_back('{32'hFFFFFFFF, 1'b0, 2'd1, MODES_EN ? 16'h4F7F : 16'h4F80, 5'h10});
    foreach (tbl[i]) begin
      run_beat(tbl[i].d, tbl[i].s, tbl[i].m, od, of, lat);
      chk_cnt++;
      if (od !== tbl[i].ed || of !== tbl[i].ef)
        $display("FAIL directed[%0d] in=%h got %h/%h want %h/%h", i, tbl[i].d, od, of, tbl[i].ed, tbl[i].ef);
      else pass_cnt++;
      if (i == 0) begin
        chk_cnt++;
        if (lat !== 3) $display("FAIL latency got %0d want 3", lat);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_half_precision();
    vec_t tbl[$];
    logic [15:0] od, ed; logic [4:0] of, ef;
    logic [31:0] d; bit s; logic [1:0] m;
    tbl.push_back('{32'd65536,  1'b1, 2'd0, 16'h7C00, 5'h14});
    tbl.push_back('{32'd65536,  1'b1, 2'd1, MODES_EN ? 16'h7BFF : 16'h7C00, 5'h14});
    tbl.push_back('{-32'sd65536, 1'b1, 2'd3, MODES_EN ? 16'hFBFF : 16'hFC00, 5'h14});
    tbl.push_back('{32'd1,      1'b1, 2'd0, 16'h3C00, 5'h00});
    foreach (tbl[i]) begin
      run_beat_h(tbl[i].d, tbl[i].s, tbl[i].m, od, of);
      chk_cnt++;
      if (od !== tbl[i].ed || of !== tbl[i].ef)
        $display("FAIL half[%0d] in=%h got %h/%h want %h/%h", i, tbl[i].d, od, of, tbl[i].ed, tbl[i].ef);
      else pass_cnt++;
    end
    for (int i = 0; i < 8; i++) begin
      d = $urandom_range(0, 140000);
      s = $urandom_range(0, 1);
      if (s && $urandom_range(0, 1)) d = -d;
      m = 2'($urandom_range(0, 3));
      ref_conv(d, s, m, 5, 10, ed, ef);
      run_beat_h(d, s, m, od, of);
      chk_cnt++;
      if (od !== ed || of !== ef)
        $display("FAIL half_rand in=%h s=%0d m=%0d got %h/%h want %h/%h", d, s, m, od, of, ed, ef);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 8;
    logic [31:0] dv [N];
    logic [20:0] ev [N];
    logic [15:0] ed; logic [4:0] ef;
    bit rdy_ok = 1'b1;
    for (int i = 0; i < N; i++) begin
      dv[i] = $urandom;
      ref_conv(dv[i], 1'b1, 2'd0, 8, 7, ed, ef);
      ev[i] = {ed, ef};
    end
    out_ready = 1'b1;
    for (int c = 0; c < N + 4; c++) begin
      @(negedge clk);
      if (c < N) begin
        in_valid = 1'b1; in_data = dv[c]; in_signed = 1'b1; rnd_mode = 2'd0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c < N && in_ready !== 1'b1) rdy_ok = 1'b0;
      if (c >= 3 && c - 3 < N) begin
        chk_cnt++;
        if (out_valid !== 1'b1 || {out_data, out_flags} !== ev[c-3])
          $display("FAIL b2b[%0d] got v=%b %h/%h want %h/%h", c - 3, out_valid, out_data, out_flags, ev[c-3][20:5], ev[c-3][4:0]);
        else pass_cnt++;
      end
    end
    chk_cnt++;
    if (!rdy_ok) $display("FAIL b2b_in_ready got 0 want 1 every cycle");
    else pass_cnt++;
  endtask

  task automatic test_stream_backpressure();
    localparam int N = 32;
    logic [31:0] dv [N]; bit sv [N]; logic [1:0] mv [N];
    logic [20:0] exp_q [$];
    logic [20:0] held_v, exp_v;
    logic [15:0] ed; logic [4:0] ef;
    int sent = 0, got = 0, cyc = 0;
    bit held = 1'b0, acc = 1'b0, extra = 1'b0;
    for (int i = 0; i < N; i++) begin
      case (i % 6)
        0: dv[i] = 32'h80000000;
        1: dv[i] = 32'd0;
        default: dv[i] = $urandom;
      endcase
      sv[i] = $urandom_range(0, 1);
      mv[i] = 2'($urandom_range(0, 3));
      ref_conv(dv[i], sv[i], mv[i], 8, 7, ed, ef);
      exp_q.push_back({ed, ef});
    end
    in_valid = 1'b0;
    while (got < N && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
      if (held) begin
        chk_cnt++;
        if (out_valid !== 1'b1 || {out_data, out_flags} !== held_v)
          $display("FAIL stall_hold got v=%b %h/%h want %h/%h", out_valid, out_data, out_flags, held_v[20:5], held_v[4:0]);
        else pass_cnt++;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      if (!in_valid && sent < N && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1; in_data = dv[sent]; in_signed = sv[sent]; rnd_mode = mv[sent];
      end
      #1;
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        chk_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL stream_extra got %h/%h want no beat", out_data, out_flags);
        end else begin
          exp_v = exp_q.pop_front();
          if ({out_data, out_flags} !== exp_v)
            $display("FAIL stream[%0d] got %h/%h want %h/%h", got, out_data, out_flags, exp_v[20:5], exp_v[4:0]);
          else pass_cnt++;
        end
        got++;
      end
      held = out_valid && !out_ready;
      held_v = {out_data, out_flags};
    end
    chk_cnt++;
    if (got != N || exp_q.size() != 0) $display("FAIL stream_count got %0d want %0d", got, N);
    else pass_cnt++;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) extra = 1'b1;
    end
    chk_cnt++;
    if (extra) $display("FAIL stream_dup got extra out_valid want none");
    else pass_cnt++;
  endtask

  task automatic test_reset_inflight();
    bit leaked = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'd100 + 32'(i); in_signed = 1'b0; rnd_mode = 2'd0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk_cnt++;
    if (out_valid !== 1'b1) $display("FAIL fill_before_reset got v=%b want 1", out_valid);
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_cnt++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_flags !== 5'h00)
      $display("FAIL flush_outputs got v=%b %h/%h want 0 0000/00", out_valid, out_data, out_flags);
    else pass_cnt++;
    chk_cnt++;
    if (in_ready !== 1'b1) $display("FAIL flush_in_ready got %b want 1", in_ready);
    else pass_cnt++;
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) leaked = 1'b1;
    end
    chk_cnt++;
    if (leaked) $display("FAIL flush_leak got out_valid=1 want 0");
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = 32'd0; in_signed = 1'b0; rnd_mode = 2'd0; out_ready = 1'b1;
    in_valid_h = 1'b0; in_data_h = 32'd0; in_signed_h = 1'b0; rnd_mode_h = 2'd0; out_ready_h = 1'b1;
    test_reset();
    test_directed();
    test_half_precision();
    test_back_to_back();
    test_stream_backpressure();
    test_reset_inflight();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
